// File: rtl/sensor_sample_sched_pkg.sv
// Shared types and default sizing for the periodic light-sensor sampler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package sensor_sample_sched_pkg;

   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_PERIOD_W = 16;
   localparam int DEF_AVG_LOG2 = 2;
   localparam int DEF_TIMEOUT  = 64;
   localparam int DEF_GAP      = 4;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_REQ     = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_WRITE   = 3'd4,
      ST_RELEASE = 3'd5
   } state_e;

   // Sample counter sticks at all-ones rather than wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sample_avg_acc.sv
// Block averager: sums 2^AVG_LOG2 bytes and publishes the truncated mean.
// Latency: avg_o/avg_valid_o update one cycle after the add that closes a window.
// Backpressure: none; every add_i strobe is absorbed in its cycle.
module sample_avg_acc
   import sensor_sample_sched_pkg::*;
#(
   parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              add_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] avg_o,
   output logic              avg_valid_o
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  sum;
   logic [WIN_W-1:0]  win_q;
   logic [DATA_W-1:0] avg_q;
   logic              avg_vld_q;

   // Accumulator is wide enough that a full window of 8'hFF cannot overflow.
   assign sum = acc_q + ACC_W'(data_i);

   // Accumulate each strobed byte; on the last byte of a window publish and restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         win_q     <= '0;
         avg_q     <= '0;
         avg_vld_q <= 1'b0;
      end else begin
         avg_vld_q <= 1'b0;
         if (add_i) begin
            if (win_q == WIN_LAST) begin
               avg_q     <= DATA_W'(sum >> AVG_LOG2);
               avg_vld_q <= 1'b1;
               acc_q     <= '0;
               win_q     <= '0;
            end else begin
               acc_q <= sum;
               win_q <= win_q + 1'b1;
            end
         end
      end
   end

   assign avg_o       = avg_q;
   assign avg_valid_o = avg_vld_q;

endmodule

// File: rtl/sensor_sample_sched.sv
// Periodic SPI frame requester that logs results to a ring buffer and averages them.
// Latency: spi_valid rises period_cfg cycles after WAIT entry; mem_we 2 cycles after spi_ready.
// Backpressure: holds spi_valid until spi_ready or TIMEOUT; waits out a stuck-high spi_ready.
module sensor_sample_sched
   import sensor_sample_sched_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int GAP      = DEF_GAP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period_cfg,
   output logic                spi_valid,
   input  logic                spi_ready,
   input  logic [DATA_W-1:0]   spi_data,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   avg_out,
   output logic                avg_valid,
   output logic [15:0]         sample_cnt,
   output logic                timeout_err,
   output logic                busy
);

   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] per_q, per_d, per_init;
   logic [TO_W-1:0]     to_q, to_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic [15:0]         cnt_q;
   logic                err_q;
   logic                en_q;
   logic                cap_en;
   logic                wr_en;
   logic                to_hit;

   // A zero period would never reach the "count at 1" exit, so it runs as 1.
   assign per_init = (period_cfg == '0) ? PERIOD_W'(1) : period_cfg;

   // Next-state and timer control; enable is deliberately ignored from REQ through WRITE.
   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      to_d    = to_q;
      gap_d   = gap_q;
      cap_en  = 1'b0;
      wr_en   = 1'b0;
      to_hit  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               per_d   = per_init;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (per_q <= PERIOD_W'(1)) begin
               to_d    = '0;
               state_d = ST_REQ;
            end else begin
               per_d = per_q - PERIOD_W'(1);
            end
         end
         ST_REQ: begin
            if (spi_ready) begin
               cap_en  = 1'b1;
               state_d = ST_CAPTURE;
            end else if (to_q == TO_LAST) begin
               to_hit  = 1'b1;
               gap_d   = '0;
               state_d = ST_RELEASE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            gap_d   = '0;
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (gap_q != GAP_LAST) begin
               gap_d = gap_q + 1'b1;
            end else if (!spi_ready) begin
               if (enable) begin
                  per_d   = per_init;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and timer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         to_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         to_q    <= to_d;
         gap_q   <= gap_d;
      end
   end

   // Data byte is taken on the handshake edge itself, while spi_data is known valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         if (cap_en) begin
            data_q <= spi_data;
         end
         if (wr_en) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= sat_inc16(cnt_q);
         end
      end
   end

   // Sticky timeout flag; a new timeout outranks a simultaneous enable fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
         en_q  <= 1'b0;
      end else begin
         en_q <= enable;
         if (to_hit) begin
            err_q <= 1'b1;
         end else if (en_q && !enable) begin
            err_q <= 1'b0;
         end
      end
   end

   sample_avg_acc #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk         (clk),
      .rst         (rst),
      .add_i       (wr_en),
      .data_i      (data_q),
      .avg_o       (avg_out),
      .avg_valid_o (avg_valid)
   );

   assign spi_valid   = (state_q == ST_REQ);
   assign mem_we      = (state_q == ST_WRITE);
   assign mem_addr    = ptr_q;
   assign mem_wdata   = data_q;
   assign sample_cnt  = cnt_q;
   assign timeout_err = err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sensor_sample_sched.sv
// Directed bench for sensor_sample_sched with a queue-driven SPI master model.
// Expected writes/averages are queued by stimulus and popped by a negedge monitor.
// Direct checks cover reset, latencies, timeout, disable and pointer wrap.
module tb_sensor_sample_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] period_cfg;
   logic        spi_valid;
   logic        spi_ready;
   logic [7:0]  spi_data;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  avg_out;
   logic        avg_valid;
   logic [15:0] sample_cnt;
   logic        timeout_err;
   logic        busy;

   sensor_sample_sched dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .period_cfg  (period_cfg),
      .spi_valid   (spi_valid),
      .spi_ready   (spi_ready),
      .spi_data    (spi_data),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .avg_out     (avg_out),
      .avg_valid   (avg_valid),
      .sample_cnt  (sample_cnt),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // resp_q entries: {delay in cycles of spi_valid, data byte}
   logic [15:0] resp_q[$];
   logic [11:0] exp_wr[$];
   logic [7:0]  exp_avg[$];

   int n_cmp = 0;
   int n_bad = 0;
   int wr_seen = 0, avg_seen = 0, req_cnt = 0;
   int busy_rise_cyc = 0, valid_rise_cyc = 0, we_cyc = 0, ready_cyc = 0;
   int vlen = 0, last_vlen = 0;
   logic sv_p = 1'b0, busy_p = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {23'd0, spi_valid, mem_we, mem_addr, mem_wdata, avg_out, avg_valid,
              sample_cnt, timeout_err, busy};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_wr(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_seen < n && k < budget) begin
         step(1);
         k++;
      end
      chk(tag, 64'(wr_seen), 64'(n));
   endtask

   task automatic wait_avg(input int n, input int budget, input string tag);
      int k = 0;
      while (avg_seen < n && k < budget) begin
         step(1);
         k++;
      end
      chk(tag, 64'(avg_seen), 64'(n));
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int k = 0;
      while (!spi_valid && k < budget) begin
         step(1);
         k++;
      end
      chk(tag, 64'(spi_valid), 64'd1);
   endtask

   // SPI master model: raises spi_ready for one cycle after the queued delay.
   initial begin
      int mcnt = 0;
      spi_ready = 1'b0;
      spi_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (spi_ready) begin
            spi_ready = 1'b0;
         end else if (spi_valid) begin
            mcnt++;
            if (resp_q.size() > 0 && mcnt >= int'(resp_q[0][15:8])) begin
               spi_data  = resp_q[0][7:0];
               spi_ready = 1'b1;
               ready_cyc = cyc;
               void'(resp_q.pop_front());
               mcnt = 0;
            end
         end else begin
            mcnt = 0;
         end
      end
   end

   // Monitor: timing bookkeeping plus scoreboard pops on writes and averages.
   initial begin
      logic [11:0] ew;
      logic [7:0]  ea;
      forever begin
         @(negedge clk);
         if (busy && !busy_p) busy_rise_cyc = cyc;
         if (spi_valid) begin
            if (!sv_p) begin
               req_cnt++;
               valid_rise_cyc = cyc;
               vlen = 0;
            end
            vlen++;
         end else if (sv_p) begin
            last_vlen = vlen;
         end
         sv_p   = spi_valid;
         busy_p = busy;
         if (mem_we) begin
            wr_seen++;
            we_cyc = cyc;
            if (exp_wr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                        mem_addr, mem_wdata);
            end else begin
               ew = exp_wr.pop_front();
               chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(ew));
            end
         end
         if (avg_valid) begin
            avg_seen++;
            if (exp_avg.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_avg: got 0x%0h, expected none", avg_out);
            end else begin
               ea = exp_avg.pop_front();
               chk("avg_out", 64'(avg_out), 64'(ea));
            end
         end
      end
   end

   // Stimulus
   initial begin
      int rq;
      int base_wr;
      int base_avg;
      int k;
      bit got;

      rst        = 1'b1;
      enable     = 1'b0;
      period_cfg = 16'd10;
      step(3);
      chk("reset_outputs", outs(), 64'd0);
      rst = 1'b0;
      step(2);

      // First frame slow (40 cycles), then two full windows.
      resp_q.push_back({8'd40, 8'h5A}); exp_wr.push_back({4'd0, 8'h5A});
      resp_q.push_back({8'd3, 8'h01});  exp_wr.push_back({4'd1, 8'h01});
      resp_q.push_back({8'd3, 8'h02});  exp_wr.push_back({4'd2, 8'h02});
      resp_q.push_back({8'd3, 8'h03});  exp_wr.push_back({4'd3, 8'h03});
      resp_q.push_back({8'd3, 8'h10});  exp_wr.push_back({4'd4, 8'h10});
      resp_q.push_back({8'd3, 8'h20});  exp_wr.push_back({4'd5, 8'h20});
      resp_q.push_back({8'd3, 8'h30});  exp_wr.push_back({4'd6, 8'h30});
      resp_q.push_back({8'd3, 8'h43});  exp_wr.push_back({4'd7, 8'h43});
      exp_avg.push_back(8'h18);
      exp_avg.push_back(8'h28);
      enable = 1'b1;

      wait_wr(1, 200, "first_write_seen");
      chk("valid_latency", 64'(valid_rise_cyc - busy_rise_cyc), 64'd10);
      chk("we_latency", 64'(we_cyc - ready_cyc), 64'd2);
      step(1);
      chk("sample_cnt_1", 64'(sample_cnt), 64'd1);

      wait_wr(8, 600, "eight_writes_seen");
      wait_avg(2, 20, "two_avgs_seen");
      step(1);
      chk("sample_cnt_8", 64'(sample_cnt), 64'd8);

      // No response queued: next request must time out.
      k = 0;
      while (!timeout_err && k < 200) begin
         step(1);
         k++;
      end
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      chk("timeout_valid_len", 64'(last_vlen), 64'd64);
      chk("timeout_no_write", 64'(wr_seen), 64'd8);
      resp_q.push_back({8'd3, 8'h77}); exp_wr.push_back({4'd8, 8'h77});
      wait_wr(9, 120, "after_timeout_write");
      chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

      // Drop enable in the middle of WAIT.
      step(8);
      rq = req_cnt;
      enable = 1'b0;
      step(20);
      chk("disable_wait_no_req", 64'(req_cnt), 64'(rq));
      chk("disable_wait_idle", 64'(busy), 64'd0);
      chk("disable_clears_err", 64'(timeout_err), 64'd0);
      chk("avg_preserved", 64'(avg_out), 64'h28);
      chk("cnt_preserved", 64'(sample_cnt), 64'd9);

      // Drop enable during REQ: frame still completes at the preserved pointer.
      resp_q.push_back({8'd20, 8'h99}); exp_wr.push_back({4'd9, 8'h99});
      rq = req_cnt;
      enable = 1'b1;
      wait_valid(50, "req_reached");
      step(5);
      enable = 1'b0;
      wait_wr(10, 100, "disable_req_write");
      step(10);
      chk("disable_req_idle", 64'(busy), 64'd0);
      chk("disable_req_one_req", 64'(req_cnt), 64'(rq + 1));
      chk("sample_cnt_10", 64'(sample_cnt), 64'd10);

      // Reset while in REQ.
      enable = 1'b1;
      wait_valid(50, "rst_req_reached");
      step(3);
      rst = 1'b1;
      #1;
      chk("rst_in_req", outs(), 64'd0);
      enable = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);

      // Reset while in WRITE: the write is cut off and never counted.
      resp_q.push_back({8'd3, 8'hBB});
      enable = 1'b1;
      got = 1'b0;
      k = 0;
      while (!got && k < 200) begin
         @(posedge clk);
         #1;
         if (mem_we) got = 1'b1;
         k++;
      end
      chk("rst_write_reached", 64'(got), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_in_write", outs(), 64'd0);
      enable = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);

      // 17 frames after reset: pointer restarts at 0 and wraps after 15.
      base_wr  = wr_seen;
      base_avg = avg_seen;
      for (int i = 0; i < 17; i++) begin
         resp_q.push_back({8'd2, 8'(i + 1)});
         exp_wr.push_back({4'(i), 8'(i + 1)});
      end
      exp_avg.push_back(8'd2);
      exp_avg.push_back(8'd6);
      exp_avg.push_back(8'd10);
      exp_avg.push_back(8'd14);
      enable = 1'b1;
      wait_wr(base_wr + 17, 17 * 40, "wrap_writes_seen");
      step(1);
      chk("sample_cnt_17", 64'(sample_cnt), 64'd17);
      chk("wrap_avg_count", 64'(avg_seen), 64'(base_avg + 4));
      enable = 1'b0;
      step(10);

      chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
      chk("exp_avg_drained", 64'(exp_avg.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sensor_sample_sched.md
Name: sensor_sample_sched

Overview:
Periodic sample sequencer for the 16-bit SPI light-sensor master. Every programmed period it requests one SPI frame via the master's valid/ready handshake and captures the 8-bit result. It writes each result into a circular sample memory and maintains a block average over 2^AVG_LOG2 samples. It sits between the top-level control/config logic and the SPI master and is the master's only requester.

Parameters:
ADDR_W, 4, sample-memory address width; memory depth = 2^ADDR_W
PERIOD_W, 16, width of the sample-period counter
AVG_LOG2, 2, log2 of the averaging window (window = 4 samples)
TIMEOUT, 64, max clk cycles to wait for spi_ready after spi_valid rises
GAP, 4, min clk cycles with spi_valid low between frames

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = run periodic sampling
period_cfg  in  PERIOD_W  clk cycles between frame requests; 0 treated as 1
spi_valid  out  1  request/hold an SPI frame on the master
spi_ready  in  1  master: frame complete, spi_data valid
spi_data  in  8  sensor result from master
mem_we  out  1  one-cycle write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  8  write data
avg_out  out  8  last completed window average
avg_valid  out  1  one-cycle pulse when avg_out updates
sample_cnt  out  16  total samples written, saturating at 16'hFFFF
timeout_err  out  1  sticky; set on frame timeout, cleared by rst or enable falling
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; period counter, timeout counter, accumulator, window counter and address pointer all 0.
- States: IDLE, WAIT, REQ, CAPTURE, WRITE, RELEASE.
- IDLE: if enable=1, load the period counter with max(period_cfg,1) and go to WAIT.
- WAIT: decrement the period counter each cycle. At 1, go to REQ. If enable=0, go to IDLE.
- REQ: spi_valid=1 and held. Timeout counter increments each cycle.
  - spi_ready=1 -> CAPTURE.
  - Counter reaches TIMEOUT without spi_ready -> set timeout_err, drop spi_valid, go to RELEASE. No write, accumulator unchanged.
  - enable falling in REQ is ignored until the frame completes or times out.
- CAPTURE: register spi_data, spi_valid=0, go to WRITE.
- WRITE: mem_we=1 for exactly one cycle with mem_addr=pointer and mem_wdata=captured byte.
  - Pointer increments and wraps from 2^ADDR_W-1 to 0.
  - sample_cnt increments, saturating.
  - Accumulator (8+AVG_LOG2 bits) adds the byte; window counter increments.
  - When the window completes: avg_out = accumulator >> AVG_LOG2 (truncating), avg_valid pulses in the cycle after the write, and accumulator and window counter clear.
  - Go to RELEASE.
- RELEASE: spi_valid=0. Wait until spi_ready=0 AND at least GAP cycles have elapsed.
  - Then go to WAIT (reloading period_cfg) if enable=1, else IDLE.
  - spi_ready stuck high keeps the block in RELEASE; this is not an error.
- Latency: spi_valid rises period_cfg cycles after entering WAIT; mem_we asserts 2 cycles after spi_ready is sampled high.
- period_cfg is sampled only on WAIT entry; changes mid-count take effect at the next period.
- Disabling sampling (enable=0) clears timeout_err but preserves the pointer, sample_cnt, avg_out and the partial window.

Decomposition:
- Shared package: state encoding constants and the default parameter values.
- One natural sub-module: sample_avg_acc (accumulator, window counter, avg_out/avg_valid), driven by a one-cycle add strobe plus 8-bit data.
- FSM, timers and memory pointer stay in the top module.

Test Plan:
- period_cfg=10, enable=1, the SPI master model returns 8'h5A with spi_ready 40 cycles after spi_valid -> spi_valid rises 10 cycles after enable; mem_we at addr 0 with data 8'h5A 2 cycles after spi_ready; sample_cnt=1.
- Four frames with 8'h10, 8'h20, 8'h30, 8'h43 -> avg_valid pulses once after the 4th write; avg_out=8'h28.
- Slave model never asserts spi_ready -> spi_valid drops after 64 cycles; timeout_err=1; no mem_we; next request follows normally.
- 17 frames with ADDR_W=4 -> addresses 0..15 then 0; sample_cnt=17.
- Assert rst in REQ and in WRITE -> all outputs 0 immediately, state IDLE; the next enable starts at addr 0.
- Drop enable during WAIT -> IDLE with no spi_valid. Drop enable during REQ -> frame completes, write occurs, then IDLE; busy=0.
